// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product step per cycle, optional
// two's-complement mode handled by multiplying magnitudes and fixing the sign last.
module seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           sgn_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] p_o
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, SIGN} state_e;

  state_e         state_q, state_d;
  // {accumulator (W+1 bits), multiplier (W bits)} shifted right as one register
  logic [2*W:0]   prod_q, prod_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           done_q, done_d;
  logic [2*W-1:0] p_q, p_d;

  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     sum;

  // -x in W bits also gives the right magnitude (2^(W-1)) for the most-negative value
  assign a_mag = (sgn_i && a_i[W-1]) ? -a_i : a_i;
  assign b_mag = (sgn_i && b_i[W-1]) ? -b_i : b_i;
  assign sum   = prod_q[2*W:W] + {1'b0, mcand_q};

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d = a_mag;
          prod_d  = {{(W+1){1'b0}}, b_mag};
          neg_d   = sgn_i & (a_i[W-1] ^ b_i[W-1]);
          cnt_d   = CW'(W);
          state_d = BUSY;
        end
      end
      BUSY: begin
        prod_d = prod_q[0] ? {1'b0, sum, prod_q[W-1:1]} : {1'b0, prod_q[2*W:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        p_d     = neg_q ? -prod_q[2*W-1:0] : prod_q[2*W-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Randomized scoreboard bench for seq_mult: stimulus pushes expected products,
// a negedge monitor pops them on done and checks latency, busy and p holding.
module tb_seq_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           sgn = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] p;

  seq_mult #(.W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .sgn_i(sgn), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .p_o(p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  exp_t           q[$];
  exp_t           got;
  int             cyc = 0;
  int             free_edge = 0;
  int             busy_lo = 1, busy_hi = 0;
  logic [2*W-1:0] last_p = '0;
  int             passed = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sg && x[W-1]) sx = sx - (longint'(1) << W);
    if (sg && y[W-1]) sy = sy - (longint'(1) << W);
    return (2*W)'(sx * sy);
  endfunction

  // Called just after a rising edge; the next edge samples these inputs.
  task automatic drive(input logic s, input logic sg, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t n;
    start = s; sgn = sg; a = aa; b = bb;
    if (s && (cyc + 1 >= free_edge)) begin
      n.p = ref_mul(sg, aa, bb);
      n.due = cyc + 1 + W + 1;
      q.push_back(n);
      busy_lo = cyc + 1;
      busy_hi = cyc + 1 + W;
      free_edge = cyc + 1 + W + 1 + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_free();
    for (int g = 0; g < 4 * W && cyc < free_edge; g++) idle(1);
    if (cyc < free_edge) begin
      total++;
      $display("FAIL wait_free timeout at cycle %0d: operation never completed", cyc);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", p, 0);
    q.delete();
    last_p = '0;
    busy_lo = 1; busy_hi = 0; free_edge = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL done_unexpected at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          got = q.pop_front();
          chk("done_cycle", cyc, got.due);
          chk("p_result", p, got.p);
          last_p = got.p;
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        total++;
        $display("FAIL done_missing at cycle %0d: got no done expected one at cycle %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
      chk("p_hold", p, last_p);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_p", p, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic, full-scale, zero and signed corner operands
    drive(1'b1, 1'b0, 8'd13, 8'd11);  wait_free();
    drive(1'b1, 1'b0, 8'hFF, 8'hFF);  wait_free();
    drive(1'b1, 1'b0, 8'h00, 8'hAB);  wait_free();
    drive(1'b1, 1'b1, 8'h80, 8'h80);  wait_free();
    drive(1'b1, 1'b1, 8'hFD, 8'h05);  wait_free();
    drive(1'b1, 1'b1, 8'hFD, 8'hFB);  wait_free();

    // start while busy is ignored
    drive(1'b1, 1'b0, 8'd2, 8'd3);
    idle(3);
    drive(1'b1, 1'b0, 8'd7, 8'd7);
    wait_free();

    // reset mid-operation aborts with no done, then a normal operation
    drive(1'b1, 1'b0, 8'd9, 8'd9);
    idle(3);
    do_reset();
    drive(1'b1, 1'b0, 8'd4, 8'd5);
    wait_free();

    // start held high: operands change every cycle, only accepted ones matter
    for (int i = 0; i < 60; i++) drive(1'b1, 1'($urandom), pick(), pick());
    wait_free();

    // sparse random starts
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) == 0, 1'($urandom), pick(), pick());
    wait_free();

    // random abort then recovery
    drive(1'b1, 1'b1, pick(), pick());
    idle($urandom_range(0, W));
    do_reset();
    drive(1'b1, 1'b1, 8'h80, 8'h7F);
    wait_free();
    idle(3);

    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending results expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
